// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external memory bus arbiter: default widths,
// arbiter state encoding and master index constants.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    REL  = 2'd2
  } arb_state_t;

  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: on a tie, picks the master
// that was not granted last.
module rr_pick
  import mem_bus_pkg::*;
(
  input  logic [1:0] Req,
  input  logic       Last,
  output logic       Valid,
  output logic       Sel
);

  always_comb begin
    Valid = |Req;
    Sel   = M0_IDX;
    if (&Req) begin
      Sel = ~Last;
    end else if (Req[M1_IDX]) begin
      Sel = M1_IDX;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the external memory bus, all outputs registered.
// Optional MemOK timeout is enabled by defining MEMARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner's transfer
// BUSY  | request presented to memory, waiting for MemOK (or timeout)
// REL   | one-cycle OK pulse to the granted master, then back to IDLE
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] M0Addr,
  input  logic              M0RRq,
  input  logic              M0WRq,
  input  logic [DATA_W-1:0] M0WData,
  output logic [DATA_W-1:0] M0RData,
  output logic              M0OK,
  output logic              M0Err,
  input  logic [ADDR_W-1:0] M1Addr,
  input  logic              M1RRq,
  input  logic              M1WRq,
  input  logic [DATA_W-1:0] M1WData,
  output logic [DATA_W-1:0] M1RData,
  output logic              M1OK,
  output logic              M1Err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRRq,
  output logic              MemWRq,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemOE,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemOK,
  output logic              Busy,
  output logic              Gnt
);

  arb_state_t                  state_q, state_d;
  logic                        gnt_q, gnt_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic                        rrq_q, rrq_d;
  logic                        wrq_q, wrq_d;
  logic                        busy_q, busy_d;
  logic [1:0]                  ok_q, ok_d;
  logic [1:0][DATA_W-1:0]      rdata_q, rdata_d;

  logic [1:0] req;
  logic       pick_vld;
  logic       pick_sel;

  assign req = {M1RRq | M1WRq, M0RRq | M0WRq};

  rr_pick u_rr_pick (
    .Req   (req),
    .Last  (gnt_q),
    .Valid (pick_vld),
    .Sel   (pick_sel)
  );

`ifdef MEMARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [1:0]           err_q, err_d;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_q + 1'b1) == TIMEOUT_W'(TIMEOUT);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE && pick_vld) begin
      tmo_d = '0;
    end else if (state_q == BUSY && !MemOK) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_q <= '0;
      err_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign M0Err = err_q[M0_IDX];
  assign M1Err = err_q[M1_IDX];
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_W'(TIMEOUT);
  assign M0Err = 1'b0;
  assign M1Err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rrq_d   = rrq_q;
    wrq_d   = wrq_q;
    rdata_d = rdata_q;
    ok_d    = 2'b00;
`ifdef MEMARB_TIMEOUT_EN
    err_d   = 2'b00;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_sel;
          state_d = BUSY;
          // write wins when a master raises both requests
          if (pick_sel == M1_IDX) begin
            addr_d  = M1Addr;
            wdata_d = M1WData;
            wrq_d   = M1WRq;
            rrq_d   = M1RRq & ~M1WRq;
          end else begin
            addr_d  = M0Addr;
            wdata_d = M0WData;
            wrq_d   = M0WRq;
            rrq_d   = M0RRq & ~M0WRq;
          end
        end
      end
      BUSY: begin
        if (MemOK) begin
          rrq_d       = 1'b0;
          wrq_d       = 1'b0;
          ok_d[gnt_q] = 1'b1;
          if (rrq_q) begin
            rdata_d[gnt_q] = MemRData;
          end
          state_d = REL;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rrq_d          = 1'b0;
          wrq_d          = 1'b0;
          ok_d[gnt_q]    = 1'b1;
          err_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = {DATA_W{1'b1}};
          state_d        = REL;
        end
`endif
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      gnt_q   <= M1_IDX;
      addr_q  <= '0;
      wdata_q <= '0;
      rrq_q   <= 1'b0;
      wrq_q   <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rrq_q   <= rrq_d;
      wrq_q   <= wrq_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
    end
  end

  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemRRq   = rrq_q;
  assign MemWRq   = wrq_q;
  assign MemOE    = wrq_q;
  assign Busy     = busy_q;
  assign Gnt      = gnt_q;
  assign M0OK     = ok_q[M0_IDX];
  assign M1OK     = ok_q[M1_IDX];
  assign M0RData  = rdata_q[M0_IDX];
  assign M1RData  = rdata_q[M1_IDX];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; exercises the timeout path
// when built with MEMARB_TIMEOUT_EN (TIMEOUT=4), the wait-forever path otherwise.
module tb_mem_arbiter;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic [19:0] M0Addr, M1Addr, MemAddr;
  logic        M0RRq, M0WRq, M1RRq, M1WRq;
  logic [15:0] M0WData, M1WData, M0RData, M1RData;
  logic        M0OK, M0Err, M1OK, M1Err;
  logic        MemRRq, MemWRq, MemOE, MemOK, Busy, Gnt;
  logic [15:0] MemWData, MemRData;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(TB_TMO), .TIMEOUT_W(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .M0Addr(M0Addr), .M0RRq(M0RRq), .M0WRq(M0WRq), .M0WData(M0WData),
    .M0RData(M0RData), .M0OK(M0OK), .M0Err(M0Err),
    .M1Addr(M1Addr), .M1RRq(M1RRq), .M1WRq(M1WRq), .M1WData(M1WData),
    .M1RData(M1RData), .M1OK(M1OK), .M1Err(M1Err),
    .MemAddr(MemAddr), .MemRRq(MemRRq), .MemWRq(MemWRq), .MemWData(MemWData),
    .MemOE(MemOE), .MemRData(MemRData), .MemOK(MemOK), .Busy(Busy), .Gnt(Gnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    M0Addr = '0; M0RRq = 0; M0WRq = 0; M0WData = '0;
    M1Addr = '0; M1RRq = 0; M1WRq = 0; M1WData = '0;
    MemRData = '0; MemOK = 0;
    tick(); tick();
    Rst = 1'b0;

    // reset state
    chk("rst_gnt", Gnt, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_rrq", MemRRq, 0);
    chk("rst_wrq", MemWRq, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_m0ok", M0OK, 0);

    // M0 read, memory answers after 2 cycles
    M0Addr = 20'h01234; M0RRq = 1;
    tick();
    chk("rd_rrq", MemRRq, 1);
    chk("rd_wrq", MemWRq, 0);
    chk("rd_addr", MemAddr, 20'h01234);
    chk("rd_gnt", Gnt, 0);
    chk("rd_busy", Busy, 1);
    tick();
    chk("rd_m0ok_early", M0OK, 0);
    MemOK = 1; MemRData = 16'hBEEF;
    tick();
    chk("rd_m0ok", M0OK, 1);
    chk("rd_m0rdata", M0RData, 16'hBEEF);
    chk("rd_m1ok", M1OK, 0);
    chk("rd_rrq_drop", MemRRq, 0);
    chk("rd_busy_rel", Busy, 1);
    MemOK = 0; M0RRq = 0;
    tick();
    chk("rd_m0ok_pulse", M0OK, 0);
    chk("rd_busy_idle", Busy, 0);

    // M1 write
    M1Addr = 20'hF0000; M1WData = 16'h5A5A; M1WRq = 1;
    tick();
    chk("wr_wrq", MemWRq, 1);
    chk("wr_oe", MemOE, 1);
    chk("wr_rrq", MemRRq, 0);
    chk("wr_addr", MemAddr, 20'hF0000);
    chk("wr_wdata", MemWData, 16'h5A5A);
    chk("wr_gnt", Gnt, 1);
    M1WData = 16'h0000;
    tick();
    chk("wr_wdata_hold", MemWData, 16'h5A5A);
    chk("wr_wrq_hold", MemWRq, 1);
    MemOK = 1; MemRData = 16'h1111;
    tick();
    chk("wr_m1ok", M1OK, 1);
    chk("wr_m0ok", M0OK, 0);
    chk("wr_m1rdata", M1RData, 0);
    chk("wr_wrq_drop", MemWRq, 0);
    chk("wr_oe_drop", MemOE, 0);
    MemOK = 0; M1WRq = 0;
    tick();
    chk("wr_m1ok_pulse", M1OK, 0);

    // fairness from reset, both masters held
    Rst = 1; tick(); Rst = 0;
    M0Addr = 20'h00AAA; M1Addr = 20'h00BBB; M0RRq = 1; M1RRq = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_m;
      exp_m = i[0];
      tick();
      chk("rr_gnt", Gnt, exp_m);
      chk("rr_addr", MemAddr, exp_m ? 20'h00BBB : 20'h00AAA);
      tick();
      MemOK = 1; MemRData = 16'h1000 + 16'(i);
      tick();
      chk("rr_m0ok", M0OK, !exp_m);
      chk("rr_m1ok", M1OK, exp_m);
      chk("rr_rdata", exp_m ? M1RData : M0RData, 16'h1000 + 16'(i));
      chk("rr_err", M0Err | M1Err, 0);
      MemOK = 0;
      tick();
    end

    // read+write together: write only
    M1RRq = 0; M0RRq = 1; M0WRq = 1; M0Addr = 20'h00055; M0WData = 16'hC3C3;
    tick();
    chk("rw_wrq", MemWRq, 1);
    chk("rw_rrq", MemRRq, 0);
    chk("rw_wdata", MemWData, 16'hC3C3);
    chk("rw_gnt", Gnt, 0);
    MemOK = 1; MemRData = 16'h9999;
    tick();
    chk("rw_m0ok", M0OK, 1);
    chk("rw_m0rdata", M0RData, 16'h1002);
    MemOK = 0; M0RRq = 0; M0WRq = 0;
    tick();

    // reset during BUSY aborts
    M1Addr = 20'h00077; M1RRq = 1;
    tick();
    chk("ab_busy", Busy, 1);
    chk("ab_rrq", MemRRq, 1);
    Rst = 1;
    tick();
    chk("ab_rrq_drop", MemRRq, 0);
    chk("ab_busy_drop", Busy, 0);
    chk("ab_gnt", Gnt, 1);
    chk("ab_addr", MemAddr, 0);
    chk("ab_m1ok", M1OK, 0);
    Rst = 0; M1RRq = 0; MemOK = 1; MemRData = 16'h7777;
    tick();
    chk("ab_idle_m0ok", M0OK, 0);
    chk("ab_idle_m1ok", M1OK, 0);
    chk("ab_idle_busy", Busy, 0);
    chk("ab_idle_m1rdata", M1RData, 0);
    MemOK = 0;
    tick();

    // no MemOK: timeout or indefinite wait
    M0Addr = 20'h00100; M0RRq = 1;
    tick();
`ifdef MEMARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_m0ok_early", M0OK, 0);
    end
    tick();
    chk("to_m0ok", M0OK, 1);
    chk("to_m0err", M0Err, 1);
    chk("to_m0rdata", M0RData, 16'hFFFF);
    chk("to_rrq_drop", MemRRq, 0);
    chk("to_m1ok", M1OK, 0);
    M0RRq = 0;
    tick();
    chk("to_m0ok_pulse", M0OK, 0);
    chk("to_busy_idle", Busy, 0);
`else
    repeat (20) tick();
    chk("nt_busy", Busy, 1);
    chk("nt_rrq", MemRRq, 1);
    chk("nt_m0ok", M0OK, 0);
    MemOK = 1; MemRData = 16'h0ABC;
    tick();
    chk("nt_m0ok_done", M0OK, 1);
    chk("nt_m0err", M0Err, 0);
    chk("nt_m0rdata", M0RData, 16'h0ABC);
    MemOK = 0; M0RRq = 0;
    tick();
    chk("nt_busy_idle", Busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
